// File: rtl/soduku_board_streamer_if.sv
// Cell stream interface between the board streamer and its consumers
// (display writer, UART formatter).
//
// One beat carries one cell value plus its grid coordinates.
// A beat transfers on a rising edge where cell_valid_out and cell_ready_in
// are both high.
//
// Signals:
//   cell_valid_out  producer -> consumer  a beat is present
//   cell_ready_in   consumer -> producer  the consumer accepts the beat
//   cell_value_out  producer -> consumer  BCD cell value, 0 = unsolved
//   cell_row_out    producer -> consumer  row index (4'hF on a checksum beat)
//   cell_col_out    producer -> consumer  column index (4'hF on a checksum beat)
//   last_out        producer -> consumer  marks the final beat of a stream
//
// Modports: master = the streamer, slave = a consumer.
interface soduku_board_streamer_if #(
  parameter int CELL_W = 4
);
  logic              cell_valid_out;
  logic              cell_ready_in;
  logic [CELL_W-1:0] cell_value_out;
  logic [3:0]        cell_row_out;
  logic [3:0]        cell_col_out;
  logic              last_out;

  modport master (
    output cell_valid_out,
    input  cell_ready_in,
    output cell_value_out,
    output cell_row_out,
    output cell_col_out,
    output last_out
  );

  modport slave (
    input  cell_valid_out,
    output cell_ready_in,
    input  cell_value_out,
    input  cell_row_out,
    input  cell_col_out,
    input  last_out
  );
endinterface

// File: rtl/soduku_board_streamer.sv
// Board streamer: snapshots the packed 324-bit solved board and streams it
// out one cell per valid/ready handshake, row-major, (0,0) first.
//
// Optional feature (compile-time macro SODUKU_STREAM_CHECKSUM_EN):
//   when defined, one extra beat follows cell (8,8) carrying the sum of all
//   81 snapshot cells mod 16, with row = col = 4'hF and last_out set.
//   When undefined, the stream is 81 beats and last_out marks (8,8).
//
// Ports:
//   clk_in     system clock, rising edge
//   reset_in   asynchronous, active-high reset
//   board_in   packed board, cell (r,c) at [323-4*(9r+c) -: 4]
//   start_in   snapshot board_in and begin a stream (honoured in IDLE only)
//   abort_in   synchronous abort of the stream in progress
//   busy_out   high from snapshot until the final transfer
//   done_out   one-cycle pulse after a completed (not aborted) stream
//   cell_if    cell stream, master side
module soduku_board_streamer #(
  parameter int GRID_SIZE = 9,
  parameter int CELL_W    = 4
) (
  input  logic                                  clk_in,
  input  logic                                  reset_in,
  input  logic [CELL_W*GRID_SIZE*GRID_SIZE-1:0] board_in,
  input  logic                                  start_in,
  input  logic                                  abort_in,
  output logic                                  busy_out,
  output logic                                  done_out,
  soduku_board_streamer_if.master               cell_if
);

  localparam int         BOARD_W  = CELL_W * GRID_SIZE * GRID_SIZE;
  localparam logic [3:0] LAST_IDX = 4'(GRID_SIZE - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
`ifdef SODUKU_STREAM_CHECKSUM_EN
    ST_CKSUM = 2'd2,
`endif
    ST_DONE  = 2'd3
  } state_t;

  state_t             state;
  // Snapshot is consumed by shifting left one cell per transfer, so the next
  // cell to present is always in the nibble just below the top one.
  logic [BOARD_W-1:0] snap;
  logic               valid;
  logic [CELL_W-1:0]  value;
  logic [3:0]         row;
  logic [3:0]         col;
  logic               last;

  logic               xfer;
  logic [3:0]         nxt_row;
  logic [3:0]         nxt_col;
  logic               at_final_cell;
  logic               nxt_is_final_cell;

`ifdef SODUKU_STREAM_CHECKSUM_EN
  // 81 cells of up to 15 each reach 1215, so 11 bits never wrap.
  localparam int SUM_W = 11;
  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] sum_nxt;

  function automatic logic [CELL_W-1:0] cksum_trunc(input logic [SUM_W-1:0] s);
    return s[CELL_W-1:0];
  endfunction

  assign sum_nxt = sum + {{(SUM_W-CELL_W){1'b0}}, value};
`endif

  assign xfer              = valid && cell_if.cell_ready_in;
  assign at_final_cell     = (row == LAST_IDX) && (col == LAST_IDX);
  assign nxt_col           = (col == LAST_IDX) ? 4'd0 : col + 4'd1;
  assign nxt_row           = (col == LAST_IDX) ? row + 4'd1 : row;
  assign nxt_is_final_cell = (nxt_row == LAST_IDX) && (nxt_col == LAST_IDX);

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state    <= ST_IDLE;
      snap     <= '0;
      valid    <= 1'b0;
      value    <= '0;
      row      <= '0;
      col      <= '0;
      last     <= 1'b0;
      busy_out <= 1'b0;
      done_out <= 1'b0;
`ifdef SODUKU_STREAM_CHECKSUM_EN
      sum      <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          done_out <= 1'b0;
          // start beats a simultaneous abort; abort alone does nothing here
          if (start_in) begin
            state    <= ST_SEND;
            snap     <= board_in;
            value    <= board_in[BOARD_W-1 -: CELL_W];
            row      <= '0;
            col      <= '0;
            last     <= 1'b0;
            valid    <= 1'b1;
            busy_out <= 1'b1;
`ifdef SODUKU_STREAM_CHECKSUM_EN
            sum      <= '0;
`endif
          end
        end

        ST_SEND: begin
          // abort wins over a simultaneous transfer
          if (abort_in) begin
            state    <= ST_IDLE;
            valid    <= 1'b0;
            last     <= 1'b0;
            busy_out <= 1'b0;
          end else if (xfer) begin
`ifdef SODUKU_STREAM_CHECKSUM_EN
            sum <= sum_nxt;
`endif
            if (at_final_cell) begin
`ifdef SODUKU_STREAM_CHECKSUM_EN
              state <= ST_CKSUM;
              value <= cksum_trunc(sum_nxt);
              row   <= 4'hF;
              col   <= 4'hF;
              last  <= 1'b1;
`else
              state    <= ST_DONE;
              valid    <= 1'b0;
              value    <= '0;
              row      <= '0;
              col      <= '0;
              last     <= 1'b0;
              busy_out <= 1'b0;
              done_out <= 1'b1;
`endif
            end else begin
              snap  <= {snap[BOARD_W-CELL_W-1:0], {CELL_W{1'b0}}};
              value <= snap[BOARD_W-CELL_W-1 -: CELL_W];
              row   <= nxt_row;
              col   <= nxt_col;
`ifdef SODUKU_STREAM_CHECKSUM_EN
              last  <= 1'b0;
`else
              last  <= nxt_is_final_cell;
`endif
            end
          end
        end

`ifdef SODUKU_STREAM_CHECKSUM_EN
        ST_CKSUM: begin
          if (abort_in) begin
            state    <= ST_IDLE;
            valid    <= 1'b0;
            last     <= 1'b0;
            busy_out <= 1'b0;
          end else if (xfer) begin
            state    <= ST_DONE;
            valid    <= 1'b0;
            value    <= '0;
            row      <= '0;
            col      <= '0;
            last     <= 1'b0;
            busy_out <= 1'b0;
            done_out <= 1'b1;
          end
        end
`endif

        ST_DONE: begin
          // start is deliberately not looked at here
          state    <= ST_IDLE;
          done_out <= 1'b0;
        end

        default: begin
          state    <= ST_IDLE;
          valid    <= 1'b0;
          last     <= 1'b0;
          busy_out <= 1'b0;
          done_out <= 1'b0;
        end
      endcase
    end
  end

`ifndef SODUKU_STREAM_CHECKSUM_EN
  // next-cell lookahead is only needed to flag (8,8) as last in this build
  logic unused_ok;
  assign unused_ok = nxt_is_final_cell;
`endif

  assign cell_if.cell_valid_out = valid;
  assign cell_if.cell_value_out = value;
  assign cell_if.cell_row_out   = row;
  assign cell_if.cell_col_out   = col;
  assign cell_if.last_out       = last;

endmodule

// File: doc/soduku_board_streamer.md
Name: soduku_board_streamer

Overview:
- Consumes the packed 324-bit solved board produced by soduku_solver (board_out) and streams it out one cell per handshake, row-major.
- Feeds downstream consumers: display writer, UART formatter.
- Snapshots the board on start so the solver may change its output while streaming.
- Inverse of the packed-board producer: parallel board in, serial cell beats out with a valid/ready handshake.

Parameters:
- GRID_SIZE, 9, cells per row/column; only 9 supported.
- CELL_W, 4, bits per BCD cell.

Ports:
- clk_in  input  1  system clock, rising edge.
- reset_in  input  1  asynchronous, active-high reset.
- board_in  input  CELL_W*GRID_SIZE*GRID_SIZE (324)  packed board; cell (r,c) at bits [323-4*(9r+c) -: 4], so (0,0) is at [323:320] and (8,8) at [3:0].
- start_in  input  1  request to snapshot board_in and stream it.
- abort_in  input  1  synchronous abort of the current stream.
- cell_valid_out  output  1  beat present.
- cell_ready_in  input  1  consumer accepts the beat.
- cell_value_out  output  4  BCD cell value, 0 = unsolved.
- cell_row_out  output  4  row index 0..8.
- cell_col_out  output  4  column index 0..8.
- last_out  output  1  marks the final beat.
- busy_out  output  1  high from snapshot until the final transfer.
- done_out  output  1  one-cycle pulse after a completed stream.

Behaviour:
- Reset (asynchronous, immediate):
  - State IDLE; snapshot cleared.
  - All outputs 0: cell_valid_out, cell_value_out, cell_row_out, cell_col_out, last_out, busy_out, done_out.
- States: IDLE, SEND, (CKSUM when feature enabled), DONE.
- IDLE:
  - When start_in is sampled high at edge N, capture board_in into the 324-bit snapshot, clear row/col to 0, go to SEND.
  - At N+1: busy_out=1, cell_valid_out=1 with cell (0,0). Start latency is 1 cycle.
- SEND:
  - Transfer occurs on an edge where cell_valid_out && cell_ready_in.
  - While valid && !ready: value, row, col and last are held stable. cell_valid_out never drops without a transfer, except on abort or reset.
  - Per transfer: col increments; col 8 wraps to 0 and row increments.
  - Values come from the snapshot only; board_in changes during SEND are ignored.
  - With cell_ready_in held high, one transfer per cycle: 81 cells in 81 consecutive cycles.
  - last_out=1 on cell (8,8) when the feature is disabled.
  - Transfer of the final beat goes to DONE.
- DONE:
  - done_out=1 for exactly one cycle; cell_valid_out=0, busy_out=0, last_out=0.
  - Then IDLE. A start_in high during DONE is ignored.
- Back-to-back: a new start may be accepted at the earliest in the cycle after DONE, i.e. minimum 2 idle cycles between streams.
- start_in while busy is ignored; no re-snapshot.
- abort_in high in SEND/CKSUM: next edge goes to IDLE with valid=0, busy=0, no done pulse.
  - abort_in beats a simultaneous transfer; that transfer is still counted as taken by the consumer.
  - abort_in in IDLE has no effect.
  - abort_in and start_in together in IDLE: start wins.
- Cell values above 9 are streamed unchanged; no validation is performed.
- Index outputs are 4 bits wide, values 0..8 in SEND.

Optional Feature:
- Macro: SODUKU_STREAM_CHECKSUM_EN.
- Enabled:
  - After the (8,8) transfer, the FSM enters CKSUM and emits one extra beat.
  - That beat carries cell_value_out = sum of all 81 snapshot cells mod 16, accumulated in a ≥10-bit running sum and truncated. cell_row_out=4'hF, cell_col_out=4'hF, last_out=1.
  - last_out is 0 on (8,8). Transfer of the checksum beat goes to DONE.
  - Total beats: 82.
- Disabled:
  - No CKSUM state and no accumulator; 81 beats, last_out on (8,8).

Test Plan:
- Reset mid-stream: after 20 transfers, pulse reset_in asynchronously -> all outputs 0 within the same cycle, state IDLE; a following start streams from (0,0).
- Full-rate stream of the solved board whose row 0 is 2,5,4,8,1,3,6,9,7, ready held high -> beats 0..8 carry those values with row=0, col=0..8; beat 80 is (8,8)=8 with last_out=1; done_out pulses exactly one cycle later; 81 busy cycles total.
- Backpressure: toggle cell_ready_in low for 3 cycles at beat 10 ((1,1)=1) -> value/row/col held at 1/1/1 while stalled; no beat lost or duplicated; all 81 beats in order.
- Snapshot isolation: after start, change board_in cell (0,0) from 2 to 0 -> streamed (0,0) still 2; start_in pulsed during SEND has no effect on indices.
- Abort: assert abort_in at beat 40 -> next cycle valid=0, busy=0, done_out stays 0; a new start restarts at (0,0).
- With SODUKU_STREAM_CHECKSUM_EN, same solved board -> beat 81 has row=col=F, value=5 (405 mod 16), last_out=1; (8,8) has last_out=0; done_out follows beat 81.
